// File: rtl/ides_pkg.sv
// Shared constants and types for the behavioural IDES16 deserializer model.
package ides_pkg;

    localparam int WORD_W = 16;   // bits per deserialized word
    localparam int PAIRS  = 8;    // DDR bit pairs per word (FCLK cycles per word)
    localparam int HIST_W = 18;   // word plus one extra pair for the slipped window
    localparam int CNT_W  = 3;    // width of the pair counter

    // Last counter value before the word boundary wraps back to zero.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAIRS - 1);

    // Bit-slip phase: SLIP_1 takes the word window one bit earlier in history.
    typedef enum logic {
        SLIP_0 = 1'b0,
        SLIP_1 = 1'b1
    } slip_e;

endpackage

// File: rtl/ides_ddr_sampler.sv
// DDR front end: captures the even bit on the falling edge and presents the
// (even, odd) pair to be registered on the following rising edge.
module ides_ddr_sampler (
    input  logic fclk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic even_o,
    output logic odd_o
);

    logic even_q;

    // Even bit is driven while FCLK is high, so it is stable at the falling edge.
    always_ff @(negedge fclk_i or posedge rst_i) begin
        if (rst_i) begin
            even_q <= 1'b0;
        end else begin
            even_q <= d_i;
        end
    end

    // Odd bit is taken straight from the line; the consumer registers it on posedge.
    assign even_o = even_q;
    assign odd_o  = d_i;

endmodule

// File: rtl/ides16_fclk.sv
// Behavioural 1:16 DDR deserializer (receive side of OSER16) with CALIB bit-slip.
// A word is presented on Q0..Q15 with a one-cycle VALID every 8 FCLK cycles,
// or 9 when a bit-slip held the pair counter.
module ides16_fclk
    import ides_pkg::*;
#(
    parameter GSREN = "false",
    parameter LSREN = "true"
) (
    input  logic FCLK,
    input  logic RESET,
    input  logic D,
    input  logic CALIB,
    output logic Q0,
    output logic Q1,
    output logic Q2,
    output logic Q3,
    output logic Q4,
    output logic Q5,
    output logic Q6,
    output logic Q7,
    output logic Q8,
    output logic Q9,
    output logic Q10,
    output logic Q11,
    output logic Q12,
    output logic Q13,
    output logic Q14,
    output logic Q15,
    output logic VALID
);

    // Primitive-compatibility parameters have no behavioural effect; RESET is always honoured.
    logic unused_params;
    assign unused_params = ^{GSREN, LSREN};

    logic even_w;
    logic odd_w;

    ides_ddr_sampler u_sampler (
        .fclk_i (FCLK),
        .rst_i  (RESET),
        .d_i    (D),
        .even_o (even_w),
        .odd_o  (odd_w)
    );

    logic [HIST_W-1:0] hist_q,   hist_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    slip_e             slip_q,   slip_d;
    logic              primed_q, primed_d;
    logic              calib_prev_q;
    logic [WORD_W-1:0] word_q,   word_d;
    logic              valid_q,  valid_d;
    logic              calib_rise;
    logic              emit;

    // Next-state: pair history shift, counter with slip hold, slip toggle, word capture.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        calib_rise = CALIB & ~calib_prev_q;
        hist_d     = {odd_w, even_w, hist_q[HIST_W-1:2]};
        slip_d     = slip_q;
        cnt_d      = cnt_q + 1'b1;
        if (calib_rise) begin
            if (slip_q == SLIP_0) begin
                // Moving to the earlier window needs one extra pair, so the counter waits.
                slip_d = SLIP_1;
                cnt_d  = cnt_q;
            end else begin
                slip_d = SLIP_0;
            end
        end
        primed_d = primed_q | ((cnt_q == CNT_LAST) && (cnt_d == '0));
        emit     = primed_q && (cnt_q == '0);
        word_d   = word_q;
        if (emit) begin
            word_d = (slip_q == SLIP_1) ? hist_q[HIST_W-2:1] : hist_q[HIST_W-1:2];
        end
        valid_d = emit;
    end

    // State and registered outputs; RESET clears everything asynchronously.
    always_ff @(posedge FCLK or posedge RESET) begin
        if (RESET) begin
            hist_q       <= '0;
            cnt_q        <= '0;
            slip_q       <= SLIP_0;
            primed_q     <= 1'b0;
            calib_prev_q <= 1'b0;
            word_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            hist_q       <= hist_d;
            cnt_q        <= cnt_d;
            slip_q       <= slip_d;
            primed_q     <= primed_d;
            calib_prev_q <= CALIB;
            word_q       <= word_d;
            valid_q      <= valid_d;
        end
    end

    assign Q0    = word_q[0];
    assign Q1    = word_q[1];
    assign Q2    = word_q[2];
    assign Q3    = word_q[3];
    assign Q4    = word_q[4];
    assign Q5    = word_q[5];
    assign Q6    = word_q[6];
    assign Q7    = word_q[7];
    assign Q8    = word_q[8];
    assign Q9    = word_q[9];
    assign Q10   = word_q[10];
    assign Q11   = word_q[11];
    assign Q12   = word_q[12];
    assign Q13   = word_q[13];
    assign Q14   = word_q[14];
    assign Q15   = word_q[15];
    assign VALID = valid_q;

endmodule

// File: tb/tb_ides16_fclk.sv
// Directed bench for ides16_fclk: the bench serializes a bit stream OSER16-style
// (even bit while FCLK high, odd bit while FCLK low) and checks words and strobes.
module tb_ides16_fclk;

    logic FCLK  = 1'b0;
    logic RESET = 1'b0;
    logic D     = 1'b0;
    logic CALIB = 1'b0;
    logic Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, Q9, Q10, Q11, Q12, Q13, Q14, Q15;
    logic VALID;

    ides16_fclk dut (
        .FCLK  (FCLK),
        .RESET (RESET),
        .D     (D),
        .CALIB (CALIB),
        .Q0    (Q0),  .Q1  (Q1),  .Q2  (Q2),  .Q3  (Q3),
        .Q4    (Q4),  .Q5  (Q5),  .Q6  (Q6),  .Q7  (Q7),
        .Q8    (Q8),  .Q9  (Q9),  .Q10 (Q10), .Q11 (Q11),
        .Q12   (Q12), .Q13 (Q13), .Q14 (Q14), .Q15 (Q15),
        .VALID (VALID)
    );

    always #5 FCLK = ~FCLK;

    wire [15:0] q_w = {Q15, Q14, Q13, Q12, Q11, Q10, Q9, Q8,
                       Q7, Q6, Q5, Q4, Q3, Q2, Q1, Q0};

    int tests = 0;
    int fails = 0;

    // Stream source: constant pattern or incrementing words, with a bit offset.
    logic        mode_inc = 1'b0;
    logic [15:0] pat      = '0;
    logic [15:0] base     = '0;
    int          off      = 0;
    int          bi       = 0;

    // Posedge numbering since reset release, and VALID bookkeeping.
    int          pcount       = 0;
    int          last_valid_p = 0;
    int          last_gap     = 0;
    logic [15:0] last_q       = '0;

    function automatic logic stream_bit(input int i);
        int          j;
        logic [15:0] w;
        j = i + off;
        w = mode_inc ? (base + 16'(j / 16)) : pat;
        return w[j % 16];
    endfunction

    // One FCLK cycle: sample outputs after posedge, drive CALIB, then the two data bits.
    task automatic cycle(input logic c, output logic v);
        @(posedge FCLK);
        #1;
        pcount++;
        v = VALID;
        if (VALID === 1'b1) begin
            last_gap     = pcount - last_valid_p;
            last_valid_p = pcount;
            last_q       = q_w;
        end
        CALIB = c;
        D = stream_bit(bi);
        bi++;
        @(negedge FCLK);
        #1;
        D = stream_bit(bi);
        bi++;
    endtask

    task automatic wait_valid(input string name, output logic ok);
        logic v;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            cycle(1'b0, v);
            if (v === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s: no VALID within 20 cycles", name);
        end
    endtask

    task automatic assert_reset();
        logic v;
        @(negedge FCLK);
        #3 RESET = 1'b1;
        for (int n = 0; n < 3; n++) cycle(1'b0, v);
    endtask

    // Release RESET just after a posedge so the next posedge captures stream pair 1.
    task automatic release_reset(input logic mi, input logic [15:0] p,
                                 input logic [15:0] b, input int o);
        mode_inc = mi;
        pat      = p;
        base     = b;
        off      = o;
        @(posedge FCLK);
        #1;
        CALIB = 1'b0;
        D     = stream_bit(0);
        bi    = 1;
        #1 RESET = 1'b0;
        pcount       = 0;
        last_valid_p = 0;
        @(negedge FCLK);
        #1;
        D  = stream_bit(1);
        bi = 2;
    endtask

    task automatic check_word(input string name, input logic [15:0] exp_q, input int exp_gap);
        tests++;
        if (last_q !== exp_q) begin
            fails++;
            $display("FAIL %s word: got %h expected %h", name, last_q, exp_q);
        end
        tests++;
        if (last_gap !== exp_gap) begin
            fails++;
            $display("FAIL %s gap: got %0d expected %0d", name, last_gap, exp_gap);
        end
    endtask

    task automatic test_reset();
        logic v;
        #2 RESET = 1'b1;
        #1;
        tests++;
        if (q_w !== 16'h0000 || VALID !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: got Q=%h VALID=%b expected Q=0000 VALID=0", q_w, VALID);
        end
        pat = 16'h6A6A;
        for (int n = 0; n < 3; n++) cycle(1'b0, v);
        tests++;
        if (q_w !== 16'h0000 || v !== 1'b0) begin
            fails++;
            $display("FAIL reset_held: got Q=%h VALID=%b expected Q=0000 VALID=0", q_w, v);
        end
    endtask

    task automatic test_pattern_5555();
        logic v;
        logic exp_v;
        release_reset(1'b0, 16'h5555, 16'h0000, 0);
        for (int k = 0; k < 25; k++) begin
            cycle(1'b0, v);
            exp_v = (pcount >= 9) && ((pcount - 9) % 8 == 0);
            tests++;
            if (v !== exp_v) begin
                fails++;
                $display("FAIL p5555 valid@%0d: got %b expected %b", pcount, v, exp_v);
            end
            tests++;
            if (pcount < 9 && q_w !== 16'h0000) begin
                fails++;
                $display("FAIL p5555 early_q@%0d: got %h expected 0000", pcount, q_w);
            end else if (pcount >= 9 && q_w !== 16'h5555) begin
                fails++;
                $display("FAIL p5555 q@%0d: got %h expected 5555", pcount, q_w);
            end
        end
    endtask

    task automatic test_loopback_calib();
        logic ok;
        logic v;
        int   pulses;
        assert_reset();
        release_reset(1'b0, 16'hA53C, 16'h0000, 5);
        wait_valid("loop_first", ok);
        check_word("loop_first", 16'hE529, 9);
        pulses = 0;
        while (last_q !== 16'hA53C && pulses < 16) begin
            cycle(1'b1, v);
            wait_valid("loop_pulse", ok);
            wait_valid("loop_pulse", ok);
            pulses++;
        end
        tests++;
        if (pulses !== 11) begin
            fails++;
            $display("FAIL loop_pulses: got %0d expected 11", pulses);
        end
        for (int n = 0; n < 3; n++) begin
            wait_valid("loop_stable", ok);
            check_word("loop_stable", 16'hA53C, 8);
        end
    endtask

    task automatic test_sixteen_slips();
        logic ok;
        logic v;
        for (int p = 0; p < 16; p++) begin
            cycle(1'b1, v);
            for (int n = 0; n < 19; n++) cycle(1'b0, v);
        end
        wait_valid("slip16", ok);
        wait_valid("slip16", ok);
        check_word("slip16", 16'hA53C, 8);
    endtask

    task automatic test_calib_held();
        logic ok;
        logic v;
        for (int n = 0; n < 30; n++) cycle(1'b1, v);
        wait_valid("held", ok);
        wait_valid("held", ok);
        check_word("held", 16'h529E, 8);
    endtask

    task automatic test_inc_slips();
        logic ok;
        logic v;
        assert_reset();
        release_reset(1'b1, 16'h0000, 16'h3C01, 0);
        wait_valid("inc_w0", ok);
        check_word("inc_w0", 16'h3C01, 9);
        wait_valid("inc_w1", ok);
        check_word("inc_w1", 16'h3C02, 8);
        wait_valid("inc_w2", ok);
        check_word("inc_w2", 16'h3C03, 8);
        cycle(1'b1, v);
        wait_valid("inc_slip1", ok);
        check_word("inc_slip1", 16'h9E02, 9);
        wait_valid("inc_slip1_next", ok);
        check_word("inc_slip1_next", 16'h1E02, 8);
        cycle(1'b1, v);
        wait_valid("inc_slip2", ok);
        check_word("inc_slip2", 16'hCF01, 8);
    endtask

    task automatic test_slip_at_cnt7();
        logic ok;
        logic v;
        for (int n = 0; n < 5; n++) cycle(1'b0, v);
        cycle(1'b1, v);
        wait_valid("cnt7", ok);
        check_word("cnt7", 16'h0780, 9);
        wait_valid("cnt7_next", ok);
        check_word("cnt7_next", 16'h2781, 8);
    endtask

    task automatic test_mid_reset();
        logic ok;
        logic v;
        int   early;
        wait_valid("midrst_pre", ok);
        #2 RESET = 1'b1;
        #1;
        tests++;
        if (q_w !== 16'h0000 || VALID !== 1'b0) begin
            fails++;
            $display("FAIL midrst_async: got Q=%h VALID=%b expected Q=0000 VALID=0", q_w, VALID);
        end
        for (int n = 0; n < 3; n++) cycle(1'b0, v);
        release_reset(1'b1, 16'h0000, 16'hBEEF, 0);
        early = 0;
        for (int n = 0; n < 8; n++) begin
            cycle(1'b0, v);
            if (v !== 1'b0) early++;
        end
        tests++;
        if (early !== 0) begin
            fails++;
            $display("FAIL midrst_stale: got %0d early VALIDs expected 0", early);
        end
        wait_valid("midrst_first", ok);
        check_word("midrst_first", 16'hBEEF, 9);
    endtask

    initial begin
        test_reset();
        test_pattern_5555();
        test_loopback_calib();
        test_sixteen_slips();
        test_calib_held();
        test_inc_slips();
        test_slip_at_cnt7();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
